// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the MEM-stage access unit.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StResp = 2'd2
  } state_e;

  localparam logic [31:0] WordAlignMask = 32'hFFFF_FFFC;

  function automatic logic is_misaligned(logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/response channel between the MEM stage and memory.
interface mem_access_unit_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/mem_access_unit_wait_timer.sv
// Saturating wait counter for outstanding accesses; flags expiry at MaxWait.
module mem_access_unit_wait_timer #(
  parameter int unsigned MaxWait = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned Width = (MaxWait == 0) ? 1 : $clog2(MaxWait + 1);
  // With MaxWait == 0 the counter still saturates, it just never expires.
  localparam logic [Width-1:0] Limit = (MaxWait == 0) ? {Width{1'b1}} : Width'(MaxWait);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != Limit)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (MaxWait != 0) && (count_q == Limit);

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: issues word loads/stores, stalls the pipeline while an access is
// outstanding and registers the stage result into the MEM/WB outputs.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned MaxWait = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [31:0]              ex_mem_alu_result_i,
  input  logic                     ex_mem_memtoreg_i,
  input  logic [4:0]               ex_mem_rd_i,
  input  logic                     ex_mem_regwrite_i,
  input  logic                     ex_mem_memread_i,
  input  logic                     ex_mem_memwrite_i,
  input  logic [31:0]              ex_mem_rs2_data_i,
  mem_access_unit_if.master        dmem,
  output logic                     mem_stall_o,
  output logic                     mem_misaligned_o,
  output logic                     mem_timeout_o,
  output logic [31:0]              mem_wb_alu_result_o,
  output logic [31:0]              mem_wb_mem_data_o,
  output logic                     mem_wb_memtoreg_o,
  output logic [4:0]               mem_wb_rd_o,
  output logic                     mem_wb_regwrite_o
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;

  logic [31:0] wb_alu_q, wb_alu_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        wb_memtoreg_q, wb_memtoreg_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        wb_regwrite_q, wb_regwrite_d;

  logic stall, misaligned, timeout, req_valid;
  logic complete, load_done, timer_clr, timer_en, expired;
  logic mem_op;

  mem_access_unit_wait_timer #(
    .MaxWait (MaxWait)
  ) u_wait_timer (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_i     (timer_clr),
    .en_i      (timer_en),
    .expired_o (expired)
  );

  assign mem_op = ex_mem_memread_i | ex_mem_memwrite_i;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    we_d          = we_q;
    wb_alu_d      = wb_alu_q;
    wb_data_d     = wb_data_q;
    wb_memtoreg_d = wb_memtoreg_q;
    wb_rd_d       = wb_rd_q;
    wb_regwrite_d = wb_regwrite_q;
    stall         = 1'b0;
    misaligned    = 1'b0;
    timeout       = 1'b0;
    req_valid     = 1'b0;
    complete      = 1'b0;
    load_done     = 1'b0;
    timer_clr     = 1'b0;
    timer_en      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (mem_op) begin
          if (is_misaligned(ex_mem_alu_result_i)) begin
            misaligned = 1'b1;
          end else begin
            stall     = 1'b1;
            addr_d    = ex_mem_alu_result_i & WordAlignMask;
            wdata_d   = ex_mem_rs2_data_i;
            we_d      = ex_mem_memwrite_i;
            timer_clr = 1'b1;
            state_d   = StReq;
          end
        end else begin
          complete = 1'b1;
        end
      end
      StReq: begin
        req_valid = 1'b1;
        timer_en  = 1'b1;
        // An accepted request finishes in preference to an expiring timer.
        if (dmem.req_ready && (we_q || dmem.rsp_valid)) begin
          complete  = 1'b1;
          load_done = !we_q;
          state_d   = StIdle;
        end else if (expired) begin
          timeout = 1'b1;
          state_d = StIdle;
        end else begin
          stall = 1'b1;
          if (dmem.req_ready) begin
            state_d = StResp;
          end
        end
      end
      StResp: begin
        timer_en = 1'b1;
        if (dmem.rsp_valid) begin
          complete  = 1'b1;
          load_done = 1'b1;
          state_d   = StIdle;
        end else if (expired) begin
          timeout = 1'b1;
          state_d = StIdle;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (complete) begin
      wb_alu_d      = ex_mem_alu_result_i;
      wb_memtoreg_d = ex_mem_memtoreg_i;
      wb_rd_d       = ex_mem_rd_i;
      wb_regwrite_d = ex_mem_regwrite_i;
      if (load_done) begin
        wb_data_d = dmem.rsp_rdata;
      end
    end else if (stall || misaligned || timeout) begin
      wb_regwrite_d = 1'b0;
      wb_memtoreg_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      wdata_q       <= '0;
      we_q          <= 1'b0;
      wb_alu_q      <= '0;
      wb_data_q     <= '0;
      wb_memtoreg_q <= 1'b0;
      wb_rd_q       <= '0;
      wb_regwrite_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      we_q          <= we_d;
      wb_alu_q      <= wb_alu_d;
      wb_data_q     <= wb_data_d;
      wb_memtoreg_q <= wb_memtoreg_d;
      wb_rd_q       <= wb_rd_d;
      wb_regwrite_q <= wb_regwrite_d;
    end
  end

  assign dmem.req_valid = req_valid;
  assign dmem.req_we    = we_q;
  assign dmem.req_addr  = addr_q;
  assign dmem.req_wdata = wdata_q;

  assign mem_stall_o         = stall;
  assign mem_misaligned_o    = misaligned;
  assign mem_timeout_o       = timeout;
  assign mem_wb_alu_result_o = wb_alu_q;
  assign mem_wb_mem_data_o   = wb_data_q;
  assign mem_wb_memtoreg_o   = wb_memtoreg_q;
  assign mem_wb_rd_o         = wb_rd_q;
  assign mem_wb_regwrite_o   = wb_regwrite_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench: u1 uses the default wait limit, u2 a limit of 4 for abort.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0] ex_alu;
  logic        ex_memtoreg;
  logic [4:0]  ex_rd;
  logic        ex_regwrite;
  logic        ex_memread;
  logic        ex_memwrite;
  logic [31:0] ex_rs2;

  mem_access_unit_if dmem1 ();
  mem_access_unit_if dmem2 ();

  logic        u1_stall, u1_mis, u1_tout, u1_memtoreg, u1_regwrite;
  logic [31:0] u1_alu, u1_data;
  logic [4:0]  u1_rd;
  logic        u2_stall, u2_mis, u2_tout, u2_memtoreg, u2_regwrite;
  logic [31:0] u2_alu, u2_data;
  logic [4:0]  u2_rd;

  mem_access_unit u1 (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .ex_mem_alu_result_i (ex_alu),
    .ex_mem_memtoreg_i   (ex_memtoreg),
    .ex_mem_rd_i         (ex_rd),
    .ex_mem_regwrite_i   (ex_regwrite),
    .ex_mem_memread_i    (ex_memread),
    .ex_mem_memwrite_i   (ex_memwrite),
    .ex_mem_rs2_data_i   (ex_rs2),
    .dmem                (dmem1),
    .mem_stall_o         (u1_stall),
    .mem_misaligned_o    (u1_mis),
    .mem_timeout_o       (u1_tout),
    .mem_wb_alu_result_o (u1_alu),
    .mem_wb_mem_data_o   (u1_data),
    .mem_wb_memtoreg_o   (u1_memtoreg),
    .mem_wb_rd_o         (u1_rd),
    .mem_wb_regwrite_o   (u1_regwrite)
  );

  mem_access_unit #(
    .MaxWait (4)
  ) u2 (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .ex_mem_alu_result_i (ex_alu),
    .ex_mem_memtoreg_i   (ex_memtoreg),
    .ex_mem_rd_i         (ex_rd),
    .ex_mem_regwrite_i   (ex_regwrite),
    .ex_mem_memread_i    (ex_memread),
    .ex_mem_memwrite_i   (ex_memwrite),
    .ex_mem_rs2_data_i   (ex_rs2),
    .dmem                (dmem2),
    .mem_stall_o         (u2_stall),
    .mem_misaligned_o    (u2_mis),
    .mem_timeout_o       (u2_tout),
    .mem_wb_alu_result_o (u2_alu),
    .mem_wb_mem_data_o   (u2_data),
    .mem_wb_memtoreg_o   (u2_memtoreg),
    .mem_wb_rd_o         (u2_rd),
    .mem_wb_regwrite_o   (u2_regwrite)
  );

  int n_cmp = 0;
  int n_err = 0;
  int stall_cnt;
  int tout_at;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [31:0] alu, input logic [4:0] rd, input logic regwrite,
                        input logic memtoreg, input logic memread, input logic memwrite,
                        input logic [31:0] rs2);
    ex_alu      = alu;
    ex_rd       = rd;
    ex_regwrite = regwrite;
    ex_memtoreg = memtoreg;
    ex_memread  = memread;
    ex_memwrite = memwrite;
    ex_rs2      = rs2;
  endtask

  task automatic set_nop();
    set_op(32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    set_nop();
    dmem1.req_ready = 1'b0; dmem1.rsp_valid = 1'b0; dmem1.rsp_rdata = '0;
    dmem2.req_ready = 1'b0; dmem2.rsp_valid = 1'b0; dmem2.rsp_rdata = '0;
    rst_n = 1'b0;
    #1;
    check("rst_stall", u1_stall, 0);
    check("rst_req_valid", dmem1.req_valid, 0);
    check("rst_regwrite", u1_regwrite, 0);
    check("rst_alu", u1_alu, 0);
    check("rst_mem_data", u1_data, 0);
    step();
    step();
    rst_n = 1'b1;

    // ALU pass-through
    set_op(32'h1234, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    check("alu_stall", u1_stall, 0);
    step();
    set_nop();
    check("alu_rd", u1_rd, 5);
    check("alu_result", u1_alu, 32'h1234);
    check("alu_regwrite", u1_regwrite, 1);

    // Load 0x100: ready on 3rd request cycle, response 3 cycles later
    set_op(32'h100, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    stall_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      dmem1.req_ready = (c == 3);
      dmem1.rsp_valid = (c == 1) || (c == 6);
      dmem1.rsp_rdata = (c == 6) ? 32'hDEAD_BEEF : 32'hBAD0_BAD0;
      #1;
      if (c == 1) begin
        check("ld_req_valid", dmem1.req_valid, 1);
        check("ld_req_addr", dmem1.req_addr, 32'h100);
        check("ld_req_we", dmem1.req_we, 0);
      end
      if (c == 2) check("ld_bubble", u1_regwrite, 0);
      if (c == 4) check("ld_resp_valid_low", dmem1.req_valid, 0);
      if (!u1_stall) break;
      stall_cnt++;
      step();
    end
    check("ld_stall_cycles", stall_cnt, 6);
    step();
    set_nop();
    dmem1.req_ready = 1'b0; dmem1.rsp_valid = 1'b0; dmem1.rsp_rdata = '0;
    check("ld_mem_data", u1_data, 32'hDEAD_BEEF);
    check("ld_memtoreg", u1_memtoreg, 1);
    check("ld_rd", u1_rd, 7);
    check("ld_regwrite", u1_regwrite, 1);

    // Store 0x40, ready as soon as valid rises
    set_op(32'h40, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA5A5_A5A5);
    #1;
    check("st_stall_first", u1_stall, 1);
    check("st_no_req_yet", dmem1.req_valid, 0);
    step();
    dmem1.req_ready = 1'b1;
    #1;
    check("st_req_valid", dmem1.req_valid, 1);
    check("st_req_we", dmem1.req_we, 1);
    check("st_wdata", dmem1.req_wdata, 32'hA5A5_A5A5);
    check("st_addr", dmem1.req_addr, 32'h40);
    check("st_done_stall", u1_stall, 0);
    step();
    set_nop();
    dmem1.req_ready = 1'b0;
    check("st_regwrite", u1_regwrite, 0);
    check("st_alu", u1_alu, 32'h40);
    check("st_data_kept", u1_data, 32'hDEAD_BEEF);
    #1;
    check("st_idle_valid", dmem1.req_valid, 0);

    // Misaligned load after a register-writing ALU op
    set_op(32'h55, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    check("pre_mis_regwrite", u1_regwrite, 1);
    set_op(32'h102, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    #1;
    check("mis_pulse", u1_mis, 1);
    check("mis_stall", u1_stall, 0);
    check("mis_no_req", dmem1.req_valid, 0);
    step();
    set_nop();
    check("mis_bubble", u1_regwrite, 0);
    check("mis_rd_kept", u1_rd, 3);
    #1;
    check("mis_pulse_end", u1_mis, 0);
    check("mis_still_idle", dmem1.req_valid, 0);

    // Timeout on u2 (limit 4), memory never ready
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    set_op(32'h200, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    stall_cnt = 0;
    tout_at   = -1;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (u2_tout) begin
        tout_at = c;
        break;
      end
      if (u2_stall) stall_cnt++;
      step();
    end
    check("to_cycle", tout_at, 5);
    check("to_stall_cycles", stall_cnt, 5);
    check("to_stall_released", u2_stall, 0);
    step();
    set_nop();
    check("to_bubble", u2_regwrite, 0);
    #1;
    check("to_pulse_end", u2_tout, 0);
    check("to_idle", dmem2.req_valid, 0);

    // Reset while u1 waits in RESP; late response must be ignored
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    set_op(32'h77, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    check("rr_pre_alu", u1_alu, 32'h77);
    set_op(32'h300, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    step();
    dmem1.req_ready = 1'b1;
    step();
    dmem1.req_ready = 1'b0;
    #1;
    check("rr_in_resp_stall", u1_stall, 1);
    check("rr_in_resp_valid", dmem1.req_valid, 0);
    rst_n = 1'b0;
    set_nop();
    #1;
    check("rr_valid", dmem1.req_valid, 0);
    check("rr_stall", u1_stall, 0);
    check("rr_alu", u1_alu, 0);
    check("rr_regwrite", u1_regwrite, 0);
    rst_n = 1'b1;
    dmem1.rsp_valid = 1'b1;
    dmem1.rsp_rdata = 32'h5555_5555;
    step();
    dmem1.rsp_valid = 1'b0;
    check("rr_late_rsp", u1_data, 0);
    check("rr_late_regwrite", u1_regwrite, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
